// File: rtl/calc_div.sv
// Sequential unsigned restoring divider: WIDTH-bit X / Y -> Q, R via shift-and-subtract.
// Optional macro CALC_DIV_ZERO_DETECT_EN: Y=0 short-circuits to DONE with DZ=1.
module calc_div #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             START,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             BUSY,
  output logic             DONE,
  output logic             DZ,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Handshake: START is sampled only in ST_IDLE/ST_DONE; DONE pulses one cycle
  // when Q/R/DZ change, and BUSY covers every cycle spent in ST_RUN.
  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   p;
  logic [WIDTH-1:0] quo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   t;

  assign state_dbg = state;

  // Trial subtraction as addition of the two's complement of {0,Y}.
  always_comb begin
    p_sh = {p[WIDTH-1:0], dvd[WIDTH-1]};
    t    = p_sh + (~{1'b0, dvs} + {{WIDTH{1'b0}}, 1'b1});
  end

`ifdef CALC_DIV_ZERO_DETECT_EN
  logic dz_flag;
`else
  assign DZ = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      dvd   <= '0;
      dvs   <= '0;
      p     <= '0;
      quo   <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
`ifdef CALC_DIV_ZERO_DETECT_EN
      dz_flag <= 1'b0;
      DZ      <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            dvd   <= X;
            dvs   <= Y;
            p     <= '0;
            quo   <= '0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            state <= ST_RUN;
`ifdef CALC_DIV_ZERO_DETECT_EN
            dz_flag <= (Y == '0);
            // Preload the final answer and jump the counter to the finish step.
            if (Y == '0) begin
              p   <= {1'b0, X};
              quo <= '1;
              cnt <= CW'(WIDTH);
            end
`endif
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cnt == CW'(WIDTH)) begin
            Q     <= quo;
            R     <= p[WIDTH-1:0];
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= ST_DONE;
`ifdef CALC_DIV_ZERO_DETECT_EN
            DZ    <= dz_flag;
`endif
          end else begin
            dvd <= {dvd[WIDTH-2:0], 1'b0};
            cnt <= cnt + CW'(1);
            if (!t[WIDTH]) begin
              p   <= t;
              quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
              p   <= p_sh;
              quo <= {quo[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_div.sv
// Directed self-checking bench for calc_div (WIDTH=4); honours CALC_DIV_ZERO_DETECT_EN.
module tb_calc_div;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         START;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic [W-1:0] Q;
  logic [W-1:0] R;
  logic         BUSY;
  logic         DONE;
  logic         DZ;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  calc_div #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .START(START), .X(X), .Y(Y),
    .Q(Q), .R(R), .BUSY(BUSY), .DONE(DONE), .DZ(DZ), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: one START pulse, operands scrambled after accept, wait for DONE
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       output int lat, output int busy_n);
    @(negedge clk);
    START = 1'b1; X = x; Y = y;
    @(posedge clk); #1;
    START = 1'b0;
    X = W'($urandom_range(0, 15));
    Y = W'($urandom_range(0, 15));
    busy_n = BUSY ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (DONE) begin
        lat = i;
        break;
      end
      if (BUSY) busy_n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; START = 1'b0; X = '0; Y = '0;
    #12;
    n_checks++; if (Q !== 4'd0) begin n_fail++; $display("FAIL reset_q got %0d want 0", Q); end
    n_checks++; if (R !== 4'd0) begin n_fail++; $display("FAIL reset_r got %0d want 0", R); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", BUSY); end
    n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", DONE); end
    n_checks++; if (DZ !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b want 0", DZ); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int lat, busy_n;
    do_op(4'd13, 4'd3, lat, busy_n);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL nom_latency got %0d want 5", lat); end
    n_checks++; if (busy_n !== 5) begin n_fail++; $display("FAIL nom_busy_cycles got %0d want 5", busy_n); end
    n_checks++; if (Q !== 4'd4) begin n_fail++; $display("FAIL nom_q got %0d want 4", Q); end
    n_checks++; if (R !== 4'd1) begin n_fail++; $display("FAIL nom_r got %0d want 1", R); end
    n_checks++; if (DZ !== 1'b0) begin n_fail++; $display("FAIL nom_dz got %b want 0", DZ); end
    @(posedge clk); #1;
    n_checks++; if (DONE !== 1'b0) begin n_fail++; $display("FAIL nom_done_pulse got %b want 0", DONE); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (Q !== 4'd4 || R !== 4'd1) begin n_fail++; $display("FAIL nom_hold got q=%0d r=%0d want q=4 r=1", Q, R); end
  endtask

  task automatic test_edges();
    logic [W-1:0] vx [3] = '{4'd15, 4'd2, 4'd0};
    logic [W-1:0] vy [3] = '{4'd1, 4'd7, 4'd5};
    logic [W-1:0] eq [3] = '{4'd15, 4'd0, 4'd0};
    logic [W-1:0] er [3] = '{4'd0, 4'd2, 4'd0};
    int lat, busy_n;
    for (int k = 0; k < 3; k++) begin
      do_op(vx[k], vy[k], lat, busy_n);
      n_checks++;
      if (lat !== 5 || Q !== eq[k] || R !== er[k]) begin
        n_fail++;
        $display("FAIL edge_%0d got lat=%0d q=%0d r=%0d want lat=5 q=%0d r=%0d", k, lat, Q, R, eq[k], er[k]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, busy_n;
    do_op(4'd9, 4'd0, lat, busy_n);
`ifdef CALC_DIV_ZERO_DETECT_EN
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dz_latency got %0d want 1", lat); end
    n_checks++; if (DZ !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", DZ); end
`else
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL dz_latency got %0d want 5", lat); end
    n_checks++; if (DZ !== 1'b0) begin n_fail++; $display("FAIL dz_flag got %b want 0", DZ); end
`endif
    n_checks++; if (Q !== 4'd15) begin n_fail++; $display("FAIL dz_q got %0d want 15", Q); end
    n_checks++; if (R !== 4'd9) begin n_fail++; $display("FAIL dz_r got %0d want 9", R); end
    do_op(4'd13, 4'd3, lat, busy_n);
    n_checks++; if (DZ !== 1'b0 || Q !== 4'd4 || R !== 4'd1) begin n_fail++; $display("FAIL dz_clear got dz=%b q=%0d r=%0d want dz=0 q=4 r=1", DZ, Q, R); end
  endtask

  task automatic test_start_ignored();
    int lat, extra;
    @(negedge clk); START = 1'b1; X = 4'd14; Y = 4'd4;
    @(posedge clk); #1; START = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); START = 1'b1; X = 4'd1; Y = 4'd1;
    @(posedge clk); #1; START = 1'b0;
    lat = -1;
    for (int i = 3; i <= 20; i++) begin
      @(posedge clk); #1;
      if (DONE) begin lat = i; break; end
    end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL ign_latency got %0d want 5", lat); end
    n_checks++; if (Q !== 4'd3 || R !== 4'd2) begin n_fail++; $display("FAIL ign_result got q=%0d r=%0d want q=3 r=2", Q, R); end
    extra = 0;
    repeat (8) begin @(posedge clk); #1; if (DONE) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ign_single_done got %0d extra want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk); START = 1'b1; X = 4'd12; Y = 4'd5;
    @(posedge clk); #1;
    X = 4'd7; Y = 4'd2;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (DONE) begin lat = i; break; end
    end
    n_checks++; if (lat !== 5 || Q !== 4'd2 || R !== 4'd2) begin n_fail++; $display("FAIL b2b_first got lat=%0d q=%0d r=%0d want lat=5 q=2 r=2", lat, Q, R); end
    @(posedge clk); #1; START = 1'b0;
    n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept got busy=%b want 1", BUSY); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (DONE) begin lat = i; break; end
    end
    n_checks++; if (lat !== 5 || Q !== 4'd3 || R !== 4'd1) begin n_fail++; $display("FAIL b2b_second got lat=%0d q=%0d r=%0d want lat=5 q=3 r=1", lat, Q, R); end
  endtask

  task automatic test_reset_abort();
    int lat, busy_n, seen;
    @(negedge clk); START = 1'b1; X = 4'd11; Y = 4'd3;
    @(posedge clk); #1; START = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (Q !== 4'd0 || R !== 4'd0 || BUSY !== 1'b0 || DONE !== 1'b0 || DZ !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs got q=%0d r=%0d busy=%b done=%b dz=%b want all 0", Q, R, BUSY, DONE, DZ);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (8) begin @(posedge clk); #1; if (DONE || BUSY) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d active cycles want 0", seen); end
    do_op(4'd11, 4'd3, lat, busy_n);
    n_checks++; if (lat !== 5 || Q !== 4'd3 || R !== 4'd2) begin n_fail++; $display("FAIL abort_restart got lat=%0d q=%0d r=%0d want lat=5 q=3 r=2", lat, Q, R); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_edges();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
